// File: rtl/fetch_decode_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_decode_pipe_pkg                                                      |
// | Opcodes, instruction field positions and stage encoding for the front end. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fetch_decode_pipe_pkg;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_JMP   = 6'd4;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } stage_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, instr: 32'h0000_0000};

    // Instructions whose rs1/rs2 fields are true register reads.
    function automatic logic reads_regs(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_STORE);
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_decode_pipe_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_decode_pipe_hazard_detect                                            |
// | Combinational RAW comparator between the D-stage sources and E-stage rd.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_decode_pipe_hazard_detect
    import fetch_decode_pipe_pkg::*;
(
    input  logic       valid_d,
    input  logic [5:0] op_d,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic       valid_e,
    input  logic [5:0] op_e,
    input  logic [4:0] rd_e,
    output logic       stall
);

    logic src_match;

    // r0 is hard-wired zero, so a write to it never creates a dependency.
    assign src_match = (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    assign stall = valid_d && reads_regs(op_d) &&
                   valid_e && writes_reg(op_e) && src_match;

endmodule

`default_nettype wire

// File: rtl/fetch_decode_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_decode_pipe                                                          |
// | PC, instruction fetch and D/E pipeline registers with bubbles and jumps.   |
// | Optional RAW interlock built when PIPE_HAZARD_EN is defined.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_decode_pipe
    import fetch_decode_pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              imem_valid,
    output logic [5:0]        op_d,
    output logic [5:0]        op_e,
    output logic [4:0]        rs1_d,
    output logic [4:0]        rs2_d,
    output logic [4:0]        rd_e,
    output logic [15:0]       imm_e,
    output logic              stall
);

    logic [ADDR_W-1:0] pc;
    stage_t            stage_d;
    stage_t            stage_e;
    logic              jump;
    logic              unused_e_rs1;

    assign jump = stage_d.valid && (stage_d.instr[OP_MSB:OP_LSB] == OP_JMP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            stage_d <= BUBBLE;
            stage_e <= BUBBLE;
        end else if (stall) begin
            stage_e <= BUBBLE;
        end else begin
            stage_e <= stage_d;
            if (jump) begin
                // The word fetched alongside the JMP is on the wrong path.
                pc      <= stage_d.instr[IMM_LSB +: ADDR_W];
                stage_d <= BUBBLE;
            end else if (imem_valid) begin
                pc      <= pc + ADDR_W'(1);
                stage_d <= '{valid: 1'b1, instr: imem_data};
            end else begin
                stage_d <= BUBBLE;
            end
        end
    end

    assign imem_addr = pc;
    assign op_d  = stage_d.valid ? stage_d.instr[OP_MSB:OP_LSB]   : OP_NOP;
    assign rs1_d = stage_d.valid ? stage_d.instr[RS1_MSB:RS1_LSB] : 5'd0;
    assign rs2_d = stage_d.valid ? stage_d.instr[RS2_MSB:RS2_LSB] : 5'd0;
    assign op_e  = stage_e.valid ? stage_e.instr[OP_MSB:OP_LSB]   : OP_NOP;
    assign rd_e  = stage_e.valid ? stage_e.instr[RD_MSB:RD_LSB]   : 5'd0;
    assign imm_e = stage_e.valid ? stage_e.instr[IMM_MSB:IMM_LSB] : 16'd0;

    assign unused_e_rs1 = ^stage_e.instr[RS1_MSB:RS1_LSB];

`ifdef PIPE_HAZARD_EN
    fetch_decode_pipe_hazard_detect u_hazard_detect (
        .valid_d (stage_d.valid),
        .op_d    (op_d),
        .rs1_d   (rs1_d),
        .rs2_d   (rs2_d),
        .valid_e (stage_e.valid),
        .op_e    (op_e),
        .rd_e    (rd_e),
        .stall   (stall)
    );
`else
    // Without the interlock, the compiler schedules NOPs around dependencies.
    assign stall = 1'b0;
`endif

endmodule

`default_nettype wire
